// File: rtl/dac_spi_serializer.sv
// Serializes 12-bit DAC codes into 16-bit SPI frames with CS, SCLK, MOSI and LDAC sequencing.
// Define DAC_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module dac_spi_serializer #(
    parameter int unsigned SCLK_DIV   = 4,
    parameter logic [3:0]  CFG_NIBBLE = 4'b0011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sample_en,
    input  logic [11:0] sample_in,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        ldac_n,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
`ifdef DAC_OVERRUN_CNT_EN
    ,
    output logic [15:0] overrun_cnt
`endif
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CS_SETUP   = 3'd1;
    localparam logic [2:0] SHIFT      = 3'd2;
    localparam logic [2:0] CS_HOLD    = 3'd3;
    localparam logic [2:0] LDAC_PULSE = 3'd4;

    localparam logic [7:0] DivLast = 8'(SCLK_DIV - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  phase_q, phase_d;
    logic [15:0] shift_q, shift_d;
    logic        pend_valid_q, pend_valid_d;
    logic [11:0] pend_data_q, pend_data_d;
    logic        done_q, done_d;

    logic phase_end, accept, ldac_end, consume, direct;

    assign phase_end = (div_q == DivLast);
    assign accept    = enable & sample_en;
    assign ldac_end  = (state_q == LDAC_PULSE) & phase_end;
    assign consume   = ldac_end & pend_valid_q & enable;
    // A strobe landing on the final LDAC cycle with nothing pending starts the next frame directly.
    assign direct    = ldac_end & accept & ~pend_valid_q;

    always_comb begin
        state_d      = state_q;
        div_d        = 8'd0;
        phase_d      = phase_q;
        shift_d      = shift_q;
        done_d       = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        overrun      = 1'b0;

        if (state_q != IDLE && !phase_end) begin
            div_d = div_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = {CFG_NIBBLE, sample_in};
                    state_d = CS_SETUP;
                end
            end
            CS_SETUP: begin
                phase_d = 5'd0;
                if (phase_end) state_d = SHIFT;
            end
            SHIFT: begin
                // Even phases hold SCLK low, odd phases high; shift after each high phase.
                if (phase_end) begin
                    phase_d = phase_q + 5'd1;
                    if (phase_q[0]) shift_d = {shift_q[14:0], 1'b0};
                    if (phase_q == 5'd31) state_d = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (phase_end) state_d = LDAC_PULSE;
            end
            LDAC_PULSE: begin
                if (phase_end) begin
                    done_d = 1'b1;
                    if (consume) begin
                        shift_d = {CFG_NIBBLE, pend_data_q};
                        state_d = CS_SETUP;
                    end else if (direct) begin
                        shift_d = {CFG_NIBBLE, sample_in};
                        state_d = CS_SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            pend_valid_d = 1'b0;
        end else if (accept && state_q != IDLE && !direct) begin
            pend_data_d  = sample_in;
            pend_valid_d = 1'b1;
            overrun      = pend_valid_q & ~consume;
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_q        <= 8'd0;
            phase_q      <= 5'd0;
            shift_q      <= 16'd0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 12'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            shift_q      <= shift_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            done_q       <= done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign spi_cs_n   = (state_q == IDLE) | (state_q == LDAC_PULSE);
    assign spi_sclk   = (state_q == SHIFT) & phase_q[0];
    assign spi_mosi   = ((state_q == CS_SETUP) | (state_q == SHIFT)) & shift_q[15];
    assign ldac_n     = (state_q != LDAC_PULSE);
    assign frame_done = done_q;

`ifdef DAC_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt_q <= 16'd0;
        end else if (overrun && ovr_cnt_q != 16'hFFFF) begin
            ovr_cnt_q <= ovr_cnt_q + 16'd1;
        end
    end

    assign overrun_cnt = ovr_cnt_q;
`endif

endmodule
